// File: rtl/text_cell_renderer.sv
// text_cell_renderer: 80x30 character-cell pixel pipeline with an internal
// page RAM, an external 8x16 font ROM and sync/blank delayed to match r/g/b.
module text_cell_renderer #(
    parameter int          COLS       = 80,
    parameter int          ROWS       = 30,
    parameter logic [23:0] FG_RGB     = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB     = 24'h000000,
    parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        blank_b_in,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [6:0]  wr_col,
    input  logic [4:0]  wr_row,
    input  logic [7:0]  wr_char,
    output logic        wr_err,
    input  logic        clear_req,
    output logic        busy,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_b,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b
);

    localparam int          CELLS    = COLS * ROWS;
    localparam logic [11:0] LAST     = 12'(CELLS - 1);
    localparam logic [11:0] CELL_LIM = 12'(CELLS);
    localparam logic [6:0]  COL_LIM  = 7'(COLS);
    localparam logic [4:0]  ROW_LIM  = 5'(ROWS);

    typedef enum logic {IDLE, CLEAR} state_t;

    function automatic logic [11:0] cell_addr(input logic [4:0] row,
                                              input logic [6:0] col);
        return ({7'd0, row} << 6) + ({7'd0, row} << 4) + {5'd0, col};
    endfunction

    state_t          state, state_n;
    logic [11:0]     cnt;
    logic [11:0]     s1_addr;
    logic [3:0]      s1_grow, s2_grow;
    logic            s1_oob;
    logic [3:0][5:0] dly;
    logic            s1_blank;
    logic [7:0]      ram [CELLS];
    logic [7:0]      ram_q;
    logic            wr_in_range, wr_acc, clr_we, ram_we, ram_re;
    logic [11:0]     ram_waddr;
    logic [7:0]      ram_wdata;
    logic            pix_bit;

    // dly[n] = {hsync, vsync, blank_b, x[2:0]}; stage 0 doubles as S1
    assign s1_blank    = dly[0][3];
    assign busy        = (state == CLEAR);
    assign wr_ready    = (state == IDLE) & ~s1_blank;
    assign wr_acc      = wr_valid & wr_ready;
    assign wr_in_range = (wr_col < COL_LIM) & (wr_row < ROW_LIM);
    assign clr_we      = (state == CLEAR) & ~s1_blank;
    assign ram_we      = clr_we | (wr_acc & wr_in_range);
    assign ram_waddr   = clr_we ? cnt : cell_addr(wr_row, wr_col);
    assign ram_wdata   = clr_we ? CLEAR_CHAR : wr_char;
    assign ram_re      = s1_blank & ~s1_oob & (s1_addr < CELL_LIM);
    assign pix_bit     = font_data[~dly[3][2:0]];

    // Single port: reads own it during active video, writes use blanking
    always_ff @(posedge clk) begin
        if (ram_we)
            ram[ram_waddr] <= ram_wdata;
        if (ram_re)
            ram_q <= ram[s1_addr];
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (clear_req) state_n = CLEAR;
            CLEAR:   if (clr_we && cnt == LAST) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR;
            cnt       <= '0;
            s1_addr   <= '0;
            s1_grow   <= '0;
            s1_oob    <= 1'b0;
            s2_grow   <= '0;
            dly       <= {4{6'b110_000}};
            font_addr <= '0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            blank_b   <= 1'b0;
            {r, g, b} <= 24'h0;
            wr_err    <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE)
                cnt <= '0;
            else if (clr_we)
                cnt <= cnt + 12'd1;
            s1_addr   <= cell_addr(y[8:4], x[9:3]);
            s1_grow   <= y[3:0];
            s1_oob    <= y[9];
            dly[0]    <= {hsync_in, vsync_in, blank_b_in, x[2:0]};
            dly[3:1]  <= dly[2:0];
            s2_grow   <= s1_grow;
            font_addr <= {ram_q, s2_grow};
            hsync     <= dly[3][5];
            vsync     <= dly[3][4];
            blank_b   <= dly[3][3];
            if (!dly[3][3])
                {r, g, b} <= 24'h0;
            else
                {r, g, b} <= pix_bit ? FG_RGB : BG_RGB;
            wr_err <= wr_acc & ~wr_in_range;
        end
    end

endmodule
